pipeline_stage_register: RTL and testbench

PIPELINE_STAGE_REGISTER -- requirements
Module: pipeline_stage_register

---
 rtl/pipeline_stage_register_if.sv | 28 ++
 rtl/pipeline_stage_register.sv | 152 +++++++++++++++
 tb/tb_pipeline_stage_register.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_register_if.sv
// Handshake/bus bundle for pipeline_stage_register: upstream offer side, downstream present side, flush and occupancy.
interface pipeline_stage_register_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 8
);
    logic                  inValid;
    logic                  inReady;
    logic [DATA_WIDTH-1:0] inData;
    logic [CTRL_WIDTH-1:0] inCtrl;
    logic                  outValid;
    logic                  outReady;
    logic [DATA_WIDTH-1:0] outData;
    logic [CTRL_WIDTH-1:0] outCtrl;
    logic                  flush;
    logic [1:0]            occupancy;

    // Environment side: drives the offers, the downstream ready and the flush.
    modport master (
        output inValid, inData, inCtrl, outReady, flush,
        input  inReady, outValid, outData, outCtrl, occupancy
    );

    // Stage side.
    modport slave (
        input  inValid, inData, inCtrl, outReady, flush,
        output inReady, outValid, outData, outCtrl, occupancy
    );
endinterface

// File: rtl/pipeline_stage_register.sv
// Two-entry skid-buffered pipeline stage register with flush and bubble-clean control outputs.
// Optional PIPE_STAGE_PERF_EN adds stallCount/flushCount performance counters.
module pipeline_stage_register #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CTRL_WIDTH = 8
) (
    input  logic clock,
    input  logic reset,
    pipeline_stage_register_if.slave bus
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic                  in_ready_q,  in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [1:0]            occupancy_q, occupancy_d;
    logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
    logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;

    logic push;
    logic pop;

    // Handshakes use only registered ready/valid, so outReady never reaches inReady combinationally.
    assign push = bus.inValid  & in_ready_q;
    assign pop  = out_valid_q  & bus.outReady;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (bus.flush) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d     = ONE;
                        main_data_d = bus.inData;
                        main_ctrl_d = bus.inCtrl;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data_d = bus.inData;
                        main_ctrl_d = bus.inCtrl;
                    end else if (push) begin
                        state_d     = TWO;
                        skid_data_d = bus.inData;
                        skid_ctrl_d = bus.inCtrl;
                    end else if (pop) begin
                        // Clearing the enables here keeps bubbles from leaking stale control downstream.
                        state_d     = EMPTY;
                        main_ctrl_d = '0;
                    end
                end
                TWO: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        skid_ctrl_d = '0;
                    end
                end
                default: begin
                    state_d     = EMPTY;
                    main_ctrl_d = '0;
                    skid_ctrl_d = '0;
                end
            endcase
        end

        in_ready_d  = (state_d != TWO);
        out_valid_d = (state_d != EMPTY);
        occupancy_d = 2'(state_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occupancy_q <= 2'd0;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            occupancy_q <= occupancy_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign bus.inReady   = in_ready_q;
    assign bus.outValid  = out_valid_q;
    assign bus.occupancy = occupancy_q;
    assign bus.outData   = main_data_q;
    assign bus.outCtrl   = main_ctrl_q;

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Both counters wrap naturally at 2^32.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (bus.inValid && !in_ready_q) begin
            stall_count_d = stall_count_q + 32'd1;
        end
        if (bus.flush) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stallCount = stall_count_q;
    assign flushCount = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Directed self-checking bench for pipeline_stage_register (default build; perf counters checked when PIPE_STAGE_PERF_EN is defined).
module tb_pipeline_stage_register;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned CTRL_WIDTH = 8;

    logic clock;
    logic reset;
    int   vectors;
    int   miscompares;

    pipeline_stage_register_if #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) bus ();

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    pipeline_stage_register #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stallCount (stall_count),
        .flushCount (flush_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance past the next rising edge; inputs change and outputs are sampled here, away from the edge.
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.inValid  = 1'b0;
        bus.inData   = '0;
        bus.inCtrl   = '0;
        bus.outReady = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        cyc();
        vectors += 5;
        if (bus.occupancy !== 2'd0) begin miscompares++; $display("FAIL reset_occupancy got %0d want 0", bus.occupancy); end
        if (bus.outValid  !== 1'b0) begin miscompares++; $display("FAIL reset_outValid got %b want 0", bus.outValid); end
        if (bus.inReady   !== 1'b1) begin miscompares++; $display("FAIL reset_inReady got %b want 1", bus.inReady); end
        if (bus.outCtrl   !== 8'h00) begin miscompares++; $display("FAIL reset_outCtrl got %h want 00", bus.outCtrl); end
        if (bus.outData   !== 32'h0) begin miscompares++; $display("FAIL reset_outData got %h want 0", bus.outData); end
        #3 reset = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        bus.outReady = 1'b1;
        bus.inValid  = 1'b1;
        bus.inData   = 32'h0000_1234;
        bus.inCtrl   = 8'h05;
        cyc();
        bus.inValid = 1'b0;
        vectors += 4;
        if (bus.outValid  !== 1'b1)          begin miscompares++; $display("FAIL single_outValid got %b want 1", bus.outValid); end
        if (bus.outData   !== 32'h0000_1234) begin miscompares++; $display("FAIL single_outData got %h want 00001234", bus.outData); end
        if (bus.outCtrl   !== 8'h05)         begin miscompares++; $display("FAIL single_outCtrl got %h want 05", bus.outCtrl); end
        if (bus.occupancy !== 2'd1)          begin miscompares++; $display("FAIL single_occupancy got %0d want 1", bus.occupancy); end
        cyc();
        vectors += 2;
        if (bus.outValid !== 1'b0)  begin miscompares++; $display("FAIL single_drain_outValid got %b want 0", bus.outValid); end
        if (bus.outCtrl  !== 8'h00) begin miscompares++; $display("FAIL single_bubble_outCtrl got %h want 00", bus.outCtrl); end
    endtask

    task automatic test_skid();
        bus.outReady = 1'b0;
        bus.inValid  = 1'b1;
        bus.inData   = 32'h11;
        bus.inCtrl   = 8'h01;
        cyc();
        bus.inData = 32'h22;
        bus.inCtrl = 8'h02;
        cyc();
        bus.inValid = 1'b0;
        vectors += 4;
        if (bus.occupancy !== 2'd2)  begin miscompares++; $display("FAIL skid_full_occupancy got %0d want 2", bus.occupancy); end
        if (bus.inReady   !== 1'b0)  begin miscompares++; $display("FAIL skid_full_inReady got %b want 0", bus.inReady); end
        if (bus.outData   !== 32'h11) begin miscompares++; $display("FAIL skid_full_outData got %h want 11", bus.outData); end
        if (bus.outCtrl   !== 8'h01) begin miscompares++; $display("FAIL skid_full_outCtrl got %h want 01", bus.outCtrl); end
        bus.outReady = 1'b1;
        cyc();
        vectors += 4;
        if (bus.outData   !== 32'h22) begin miscompares++; $display("FAIL skid_pop1_outData got %h want 22", bus.outData); end
        if (bus.outCtrl   !== 8'h02) begin miscompares++; $display("FAIL skid_pop1_outCtrl got %h want 02", bus.outCtrl); end
        if (bus.inReady   !== 1'b1)  begin miscompares++; $display("FAIL skid_pop1_inReady got %b want 1", bus.inReady); end
        if (bus.occupancy !== 2'd1)  begin miscompares++; $display("FAIL skid_pop1_occupancy got %0d want 1", bus.occupancy); end
        cyc();
        vectors += 2;
        if (bus.occupancy !== 2'd0) begin miscompares++; $display("FAIL skid_pop2_occupancy got %0d want 0", bus.occupancy); end
        if (bus.outValid  !== 1'b0) begin miscompares++; $display("FAIL skid_pop2_outValid got %b want 0", bus.outValid); end
    endtask

    task automatic test_back_to_back();
        bus.outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.inValid = 1'b1;
            bus.inData  = 32'h100 + 32'(i);
            bus.inCtrl  = 8'h80 | 8'(i);
            cyc();
            vectors += 4;
            if (bus.outData   !== 32'h100 + 32'(i)) begin miscompares++; $display("FAIL b2b_outData[%0d] got %h want %h", i, bus.outData, 32'h100 + 32'(i)); end
            if (bus.outCtrl   !== (8'h80 | 8'(i)))  begin miscompares++; $display("FAIL b2b_outCtrl[%0d] got %h want %h", i, bus.outCtrl, 8'h80 | 8'(i)); end
            if (bus.occupancy !== 2'd1)             begin miscompares++; $display("FAIL b2b_occupancy[%0d] got %0d want 1", i, bus.occupancy); end
            if (bus.inReady   !== 1'b1)             begin miscompares++; $display("FAIL b2b_inReady[%0d] got %b want 1", i, bus.inReady); end
        end
        bus.inValid = 1'b0;
        cyc();
        vectors += 1;
        if (bus.outValid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain_outValid got %b want 0", bus.outValid); end
    endtask

    task automatic test_flush();
        bus.outReady = 1'b0;
        bus.inValid  = 1'b1;
        bus.inData   = 32'h44;
        bus.inCtrl   = 8'h04;
        cyc();
        bus.inData = 32'h55;
        bus.inCtrl = 8'h05;
        cyc();
        bus.flush  = 1'b1;
        bus.inData = 32'h33;
        bus.inCtrl = 8'hFF;
        cyc();
        bus.flush   = 1'b0;
        bus.inValid = 1'b0;
        vectors += 5;
        if (bus.occupancy !== 2'd0)  begin miscompares++; $display("FAIL flush_occupancy got %0d want 0", bus.occupancy); end
        if (bus.outValid  !== 1'b0)  begin miscompares++; $display("FAIL flush_outValid got %b want 0", bus.outValid); end
        if (bus.outCtrl   !== 8'h00) begin miscompares++; $display("FAIL flush_outCtrl got %h want 00", bus.outCtrl); end
        if (bus.inReady   !== 1'b1)  begin miscompares++; $display("FAIL flush_inReady got %b want 1", bus.inReady); end
        if (bus.outData   !== 32'h44) begin miscompares++; $display("FAIL flush_held_outData got %h want 44", bus.outData); end
        bus.outReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            vectors += 1;
            if (bus.outValid !== 1'b0 || bus.outData === 32'h33) begin
                miscompares++;
                $display("FAIL flush_no_leak[%0d] got valid=%b data=%h want valid=0 data!=33", i, bus.outValid, bus.outData);
            end
        end
    endtask

    task automatic test_async_reset();
        bus.outReady = 1'b0;
        bus.inValid  = 1'b1;
        bus.inData   = 32'h77;
        bus.inCtrl   = 8'h07;
        cyc();
        bus.inData = 32'h88;
        bus.inCtrl = 8'h08;
        cyc();
        bus.inValid = 1'b0;
        vectors += 1;
        if (bus.occupancy !== 2'd2) begin miscompares++; $display("FAIL areset_pre_occupancy got %0d want 2", bus.occupancy); end
        #2 reset = 1'b0;
        #1;
        vectors += 5;
        if (bus.occupancy !== 2'd0)  begin miscompares++; $display("FAIL areset_occupancy got %0d want 0", bus.occupancy); end
        if (bus.outValid  !== 1'b0)  begin miscompares++; $display("FAIL areset_outValid got %b want 0", bus.outValid); end
        if (bus.inReady   !== 1'b1)  begin miscompares++; $display("FAIL areset_inReady got %b want 1", bus.inReady); end
        if (bus.outCtrl   !== 8'h00) begin miscompares++; $display("FAIL areset_outCtrl got %h want 00", bus.outCtrl); end
        if (bus.outData   !== 32'h0) begin miscompares++; $display("FAIL areset_outData got %h want 0", bus.outData); end
        cyc();
        #2 reset = 1'b1;
        bus.inValid = 1'b1;
        bus.inData  = 32'h66;
        bus.inCtrl  = 8'h06;
        cyc();
        bus.inValid = 1'b0;
        vectors += 2;
        if (bus.outValid !== 1'b1)  begin miscompares++; $display("FAIL areset_first_push_outValid got %b want 1", bus.outValid); end
        if (bus.outData  !== 32'h66) begin miscompares++; $display("FAIL areset_first_push_outData got %h want 66", bus.outData); end
        bus.outReady = 1'b1;
        cyc();
    endtask

`ifdef PIPE_STAGE_PERF_EN
    task automatic test_perf();
        idle_inputs();
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        cyc();
        bus.inValid = 1'b1;
        bus.inData  = 32'hA;
        bus.inCtrl  = 8'h0A;
        cyc();
        bus.inData = 32'hB;
        cyc();
        for (int i = 0; i < 5; i++) cyc();
        bus.inValid = 1'b0;
        bus.flush   = 1'b1;
        cyc();
        cyc();
        bus.flush = 1'b0;
        cyc();
        vectors += 2;
        if (stall_count !== 32'd5) begin miscompares++; $display("FAIL perf_stallCount got %0d want 5", stall_count); end
        if (flush_count !== 32'd2) begin miscompares++; $display("FAIL perf_flushCount got %0d want 2", flush_count); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_single();
        test_skid();
        test_back_to_back();
        test_flush();
        test_async_reset();
`ifdef PIPE_STAGE_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
